spi_apb_arbiter: RTL and testbench

Round-robin arbiter that shares the single APB slave port of the SPI controller between up to NUM_MST requesters (CPU bridge, DMA, boot loader, debug). Each requester uses the same single-phase APB handshake the SPI controller accepts: paddr/pwdata/pwrite/penable asserted together, held until pready. The arbiter adds per-master bus locking, so a requester can program address/data register files plus the control register atomically. A timeout watchdog terminates transfers the slave never acknowledges.

---
 rtl/spi_apb_arbiter.sv | 160 ++++++++++++++++
 tb/tb_spi_apb_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_apb_arbiter.sv
// spi_apb_arbiter: shares the SPI controller's single APB slave port between
// NUM_MST requesters with round-robin arbitration, per-master bus locking and
// a watchdog that terminates transfers the slave never acknowledges.
//
// state  | meaning
// S_IDLE | no owner, arbitrating among m_penable_i
// S_XFER | owner g drives the slave port, waiting for s_pready_i or timeout
// S_DONE | one-cycle completion (pready/perr pulse) to owner g
// S_LOCK | owner g retains the bus between transfers
module spi_apb_arbiter #(
  parameter int NUM_MST = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                 pclk_i,
  input  logic                 prst_i,
  input  logic [8*NUM_MST-1:0] m_paddr_i,
  input  logic [8*NUM_MST-1:0] m_pwdata_i,
  input  logic [NUM_MST-1:0]   m_pwrite_i,
  input  logic [NUM_MST-1:0]   m_penable_i,
  input  logic [NUM_MST-1:0]   m_lock_i,
  output logic [NUM_MST-1:0]   m_pready_o,
  output logic [NUM_MST-1:0]   m_perr_o,
  output logic [7:0]           m_prdata_o,
  output logic [NUM_MST-1:0]   gnt_o,
  output logic [7:0]           s_paddr_o,
  output logic [7:0]           s_pwdata_o,
  output logic                 s_pwrite_o,
  output logic                 s_penable_o,
  input  logic [7:0]           s_prdata_i,
  input  logic                 s_pready_i
);

  localparam int GW = (NUM_MST > 1) ? $clog2(NUM_MST) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]      TLAST = TW'(TIMEOUT - 1);
  localparam logic [NUM_MST-1:0] ONE   = NUM_MST'(1);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_XFER = 4'b0010,
    S_DONE = 4'b0100,
    S_LOCK = 4'b1000
  } state_t;

  state_t               state_q, state_d;
  logic [GW-1:0]        g_q, g_d;
  logic [GW-1:0]        last_q, last_d;
  logic [TW-1:0]        tcnt_q, tcnt_d;
  logic [NUM_MST-1:0]   gnt_q, gnt_d;
  logic [NUM_MST-1:0]   pready_q, pready_d;
  logic [NUM_MST-1:0]   perr_q, perr_d;
  logic [7:0]           prdata_q, prdata_d;
  logic [GW-1:0]        pick;
  logic                 pick_vld;

  // Round-robin search: first requester after the last served master.
  always_comb begin : p_arb
    logic [GW-1:0] cand;
    pick     = '0;
    pick_vld = 1'b0;
    cand     = '0;
    for (int k = 1; k <= NUM_MST; k++) begin
      cand = GW'((int'(last_q) + k) % NUM_MST);
      if (!pick_vld && m_penable_i[cand]) begin
        pick_vld = 1'b1;
        pick     = cand;
      end
    end
  end

  // Next-state logic; completion outputs are prepared on the XFER->DONE edge.
  always_comb begin : p_fsm
    state_d  = state_q;
    g_d      = g_q;
    last_d   = last_q;
    tcnt_d   = tcnt_q;
    pready_d = '0;
    perr_d   = '0;
    prdata_d = '0;
    unique case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          g_d     = pick;
          tcnt_d  = '0;
          state_d = S_XFER;
        end
      end
      S_XFER: begin
        if (s_pready_i) begin
          state_d  = S_DONE;
          pready_d = ONE << g_q;
          prdata_d = s_prdata_i;
        end else if (tcnt_q == TLAST) begin
          state_d  = S_DONE;
          pready_d = ONE << g_q;
          perr_d   = ONE << g_q;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      S_DONE: begin
        last_d  = g_q;
        state_d = m_lock_i[g_q] ? S_LOCK : S_IDLE;
      end
      S_LOCK: begin
        if (m_penable_i[g_q]) begin
          tcnt_d  = '0;
          state_d = S_XFER;
        end else if (!m_lock_i[g_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    gnt_d = (state_d == S_IDLE) ? '0 : (ONE << g_d);
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge pclk_i) begin
    if (prst_i) begin
      state_q  <= S_IDLE;
      g_q      <= '0;
      last_q   <= GW'(NUM_MST - 1);
      tcnt_q   <= '0;
      gnt_q    <= '0;
      pready_q <= '0;
      perr_q   <= '0;
      prdata_q <= '0;
    end else begin
      state_q  <= state_d;
      g_q      <= g_d;
      last_q   <= last_d;
      tcnt_q   <= tcnt_d;
      gnt_q    <= gnt_d;
      pready_q <= pready_d;
      perr_q   <= perr_d;
      prdata_q <= prdata_d;
    end
  end

  // Slave port follows the owner only while a transfer is in flight.
  always_comb begin : p_smux
    s_paddr_o   = '0;
    s_pwdata_o  = '0;
    s_pwrite_o  = 1'b0;
    s_penable_o = 1'b0;
    if (state_q == S_XFER) begin
      s_paddr_o   = m_paddr_i[8*int'(g_q) +: 8];
      s_pwdata_o  = m_pwdata_i[8*int'(g_q) +: 8];
      s_pwrite_o  = m_pwrite_i[g_q];
      s_penable_o = 1'b1;
    end
  end

  assign gnt_o      = gnt_q;
  assign m_pready_o = pready_q;
  assign m_perr_o   = perr_q;
  assign m_prdata_o = prdata_q;

endmodule

// File: tb/tb_spi_apb_arbiter.sv
// tb_spi_apb_arbiter: randomized scoreboard bench; a round-robin/lock model
// predicts completion order, error flags and read data from a slave memory.
module tb_spi_apb_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic             pclk;
  logic             prst = 1'b1;
  logic [8*N-1:0]   m_paddr = '0;
  logic [8*N-1:0]   m_pwdata = '0;
  logic [N-1:0]     m_pwrite = '0;
  logic [N-1:0]     m_penable = '0;
  logic [N-1:0]     m_lock = '0;
  logic [N-1:0]     m_pready_o, m_perr_o, gnt_o;
  logic [7:0]       m_prdata_o, s_paddr_o, s_pwdata_o;
  logic             s_pwrite_o, s_penable_o;
  logic [7:0]       s_prdata = '0;
  logic             s_pready = 1'b0;

  spi_apb_arbiter #(.NUM_MST(N), .TIMEOUT(TO)) dut (
    .pclk_i(pclk), .prst_i(prst),
    .m_paddr_i(m_paddr), .m_pwdata_i(m_pwdata), .m_pwrite_i(m_pwrite),
    .m_penable_i(m_penable), .m_lock_i(m_lock),
    .m_pready_o(m_pready_o), .m_perr_o(m_perr_o), .m_prdata_o(m_prdata_o),
    .gnt_o(gnt_o),
    .s_paddr_o(s_paddr_o), .s_pwdata_o(s_pwdata_o), .s_pwrite_o(s_pwrite_o),
    .s_penable_o(s_penable_o), .s_prdata_i(s_prdata), .s_pready_i(s_pready)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  typedef struct {
    int         m;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       wr;
    logic       err;
  } txn_t;

  txn_t       plan[N][$];
  txn_t       mq[N][$];
  txn_t       expq[$];
  logic       busy[N];
  logic       lock_mode[N];
  int         issue_cyc[N];
  logic [7:0] smem[256];
  logic [7:0] rmem[256];
  int         cyc = 0;
  int         slave_mode = 0;
  int         lat_exp = -1;
  int         model_last = N - 1;
  logic       abort = 1'b0;
  int         n_chk = 0;
  int         n_fail = 0;
  logic [7:0] rec_addr, rec_wdata;
  logic       rec_wr;
  int         scnt = 0;
  int         sdelay = 0;

  initial for (int i = 0; i < N; i++) begin
    busy[i] = 1'b0; lock_mode[i] = 1'b0; issue_cyc[i] = 0;
  end

  always @(posedge pclk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  // Master drivers: hold a transfer until pready, then load the next one.
  always @(negedge pclk) begin
    for (int i = 0; i < N; i++) begin
      if (abort) begin
        mq[i].delete();
        busy[i] = 1'b0;
        m_penable[i] = 1'b0;
        m_lock[i] = 1'b0;
      end else begin
        if (busy[i] && m_pready_o[i]) busy[i] = 1'b0;
        if (!busy[i] && mq[i].size() > 0) begin
          txn_t t;
          t = mq[i].pop_front();
          busy[i] = 1'b1;
          m_paddr[8*i +: 8]  = t.addr;
          m_pwdata[8*i +: 8] = t.wdata;
          m_pwrite[i]        = t.wr;
          m_penable[i]       = 1'b1;
          issue_cyc[i]       = cyc;
        end else if (!busy[i]) begin
          m_penable[i] = 1'b0;
        end
        m_lock[i] = lock_mode[i] && busy[i];
      end
    end
  end

  // Slave: memory-backed, pready after a mode-dependent number of cycles.
  // mode 0: random 0..3 wait, 1: never, 2: on the TO-th cycle, 3: immediate.
  always @(negedge pclk) begin
    if (s_penable_o) begin
      scnt++;
      if (scnt == 1)
        sdelay = (slave_mode == 0) ? int'($urandom_range(0, 3)) :
                 (slave_mode == 1) ? 100000 :
                 (slave_mode == 2) ? TO - 1 : 0;
      if (scnt > sdelay && !s_pready) begin
        rec_addr  = s_paddr_o;
        rec_wdata = s_pwdata_o;
        rec_wr    = s_pwrite_o;
        if (s_pwrite_o) begin
          smem[s_paddr_o] = s_pwdata_o;
          s_prdata = 8'($urandom);
        end else begin
          s_prdata = smem[s_paddr_o];
        end
        s_pready = 1'b1;
      end
    end else begin
      scnt = 0;
      s_pready = 1'b0;
    end
  end

  // Monitor: every completion pulse is matched against the scoreboard.
  always @(negedge pclk) begin
    if (m_pready_o != '0) begin
      if (expq.size() == 0) begin
        chk("pready_without_request", 32'(m_pready_o), 32'h0);
      end else begin
        txn_t e;
        logic [N-1:0] oh;
        e = expq.pop_front();
        oh = '0;
        oh[e.m] = 1'b1;
        chk("pready_vec", 32'(m_pready_o), 32'(oh));
        chk("gnt_at_done", 32'(gnt_o), 32'(oh));
        chk("perr_vec", 32'(m_perr_o), e.err ? 32'(oh) : 32'h0);
        if (e.err || !e.wr) chk("prdata", 32'(m_prdata_o), 32'(e.rdata));
        if (!e.err) begin
          chk("slave_addr", 32'(rec_addr), 32'(e.addr));
          chk("slave_write", 32'(rec_wr), 32'(e.wr));
          if (e.wr) chk("slave_wdata", 32'(rec_wdata), 32'(e.wdata));
        end
        if (lat_exp >= 0) chk("latency", 32'(cyc - issue_cyc[e.m]), 32'(lat_exp));
      end
    end
  end

  task automatic add(input int m, input logic [7:0] a, input logic [7:0] d, input logic wr);
    txn_t t;
    t.m = m; t.addr = a; t.wdata = d; t.wr = wr; t.rdata = '0; t.err = 1'b0;
    plan[m].push_back(t);
  endtask

  function automatic bit pending();
    bit p;
    p = 1'b0;
    for (int i = 0; i < N; i++) if (mq[i].size() > 0 || busy[i]) p = 1'b1;
    return p;
  endfunction

  // Model: repeatedly grant the first planned master after the last served
  // one; a locking master drains its whole list in one tenure.
  task automatic run_phase(input int mode);
    int   k;
    int   budget;
    txn_t t;
    @(negedge pclk);
    slave_mode = mode;
    do begin
      k = -1;
      for (int s = 1; s <= N; s++)
        if (k < 0 && plan[(model_last + s) % N].size() > 0) k = (model_last + s) % N;
      if (k >= 0) begin
        do begin
          t = plan[k].pop_front();
          t.m = k;
          t.err = (mode == 1);
          if (t.err) t.rdata = '0;
          else if (t.wr) begin rmem[t.addr] = t.wdata; t.rdata = '0; end
          else t.rdata = rmem[t.addr];
          expq.push_back(t);
          mq[k].push_back(t);
        end while (lock_mode[k] && plan[k].size() > 0);
        model_last = k;
      end
    end while (k >= 0);
    budget = 0;
    while ((expq.size() > 0 || pending()) && budget < 3000) begin
      @(negedge pclk);
      budget++;
    end
    chk("phase_complete", 32'(expq.size()), 32'h0);
    if (expq.size() > 0) begin
      expq.delete();
      abort = 1'b1;
      repeat (2) @(negedge pclk);
      abort = 1'b0;
    end
    repeat (2) @(negedge pclk);
    chk("gnt_idle", 32'(gnt_o), 32'h0);
    chk("s_penable_idle", 32'(s_penable_o), 32'h0);
    for (int i = 0; i < N; i++) lock_mode[i] = 1'b0;
  endtask

  initial begin
    txn_t t;
    for (int a = 0; a < 256; a++) begin
      smem[a] = 8'($urandom);
      rmem[a] = smem[a];
    end
    smem[8'h10] = 8'h46;
    rmem[8'h10] = 8'h46;

    repeat (3) @(negedge pclk);
    chk("rst_gnt", 32'(gnt_o), 32'h0);
    chk("rst_pready", 32'(m_pready_o), 32'h0);
    chk("rst_perr", 32'(m_perr_o), 32'h0);
    chk("rst_prdata", 32'(m_prdata_o), 32'h0);
    chk("rst_s_penable", 32'(s_penable_o), 32'h0);
    prst = 1'b0;

    // single write, immediate slave: 3-cycle transfer
    lat_exp = 2;
    add(0, 8'h20, 8'h05, 1'b1);
    run_phase(3);
    // read of a known location
    add(2, 8'h10, 8'h00, 1'b0);
    run_phase(3);
    // unacknowledged read times out; acknowledge on the last cycle does not
    lat_exp = TO + 1;
    add(3, 8'h10, 8'h00, 1'b0);
    run_phase(1);
    add(3, 8'h10, 8'h00, 1'b0);
    run_phase(2);
    lat_exp = -1;

    // reset in the middle of a transfer
    t.m = 1; t.addr = 8'h33; t.wdata = 8'h99; t.wr = 1'b1; t.rdata = '0; t.err = 1'b0;
    @(negedge pclk);
    slave_mode = 1;
    mq[1].push_back(t);
    repeat (6) @(negedge pclk);
    chk("xfer_gnt", 32'(gnt_o), 32'h2);
    chk("xfer_s_penable", 32'(s_penable_o), 32'h1);
    chk("xfer_s_paddr", 32'(s_paddr_o), 32'h33);
    prst = 1'b1;
    abort = 1'b1;
    @(negedge pclk);
    chk("rst_mid_gnt", 32'(gnt_o), 32'h0);
    chk("rst_mid_pready", 32'(m_pready_o), 32'h0);
    chk("rst_mid_perr", 32'(m_perr_o), 32'h0);
    chk("rst_mid_s_penable", 32'(s_penable_o), 32'h0);
    chk("rst_mid_s_paddr", 32'(s_paddr_o), 32'h0);
    prst = 1'b0;
    model_last = N - 1;
    @(negedge pclk);
    abort = 1'b0;
    repeat (20) @(negedge pclk);
    chk("post_rst_gnt", 32'(gnt_o), 32'h0);

    // all four at once, then 0 and 2 again
    for (int i = 0; i < N; i++) add(i, 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
    run_phase(0);
    add(0, 8'($urandom_range(0, 15)), 8'($urandom), 1'b1);
    add(2, 8'($urandom_range(0, 15)), 8'($urandom), 1'b0);
    run_phase(0);
    add(0, 8'h05, 8'h11, 1'b1);
    run_phase(0);

    // locked master 1 against a continuous master 3
    lock_mode[1] = 1'b1;
    for (int a = 0; a < 8; a++) add(1, 8'(a), 8'($urandom), 1'b1);
    add(1, 8'h20, 8'($urandom), 1'b1);
    for (int j = 0; j < 3; j++) add(3, 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
    run_phase(0);

    // random mixes
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 2) != 0) begin
          lock_mode[i] = ($urandom_range(0, 3) == 0);
          for (int j = 0; j < int'($urandom_range(1, 3)); j++)
            add(i, 8'($urandom_range(0, 15)), 8'($urandom), 1'($urandom));
        end
      end
      run_phase(0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
